// File: rtl/ir_strobe_ctrl.sv
// ir_strobe_ctrl: trigger-driven IR LED strobe sequencer (power-up, settle, PWM burst, power-down).
module ir_strobe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_enable,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    input  logic [CNT_W-1:0] cfg_settle,
    input  logic [CNT_W-1:0] cfg_pulses,
    input  logic             cfg_boost,
    input  logic             trigger,
    input  logic             ovr_clr,
    output logic             irled_en,
    output logic             ir_pwm,
    output logic             ir_pu,
    output logic             busy,
    output logic             done,
    output logic             overrun
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] BURST  = 2'd2;
    localparam logic [CNT_W-1:0] ONE = 1;
    logic [1:0]       state;
    logic [CNT_W-1:0] per_q, duty_q, settle_q, pulses_q, set_cnt, phase, pcnt;
    logic             boost_q;
    logic             busy_trig, accept;
    // The done cycle still counts as busy so two strobes are always separated by an idle cycle.
    assign busy_trig = trigger && (busy || done);
    assign accept    = trigger && !busy && !done && cfg_enable && (cfg_pulses != '0);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            per_q    <= '0;
            duty_q   <= '0;
            settle_q <= '0;
            pulses_q <= '0;
            boost_q  <= 1'b0;
            set_cnt  <= '0;
            phase    <= '0;
            pcnt     <= '0;
            irled_en <= 1'b0;
            ir_pwm   <= 1'b0;
            ir_pu    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy_trig)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
            if (accept) begin
                per_q    <= (cfg_period == '0) ? ONE : cfg_period;
                duty_q   <= cfg_duty;
                settle_q <= cfg_settle;
                pulses_q <= cfg_pulses;
                boost_q  <= cfg_boost;
                set_cnt  <= '0;
                phase    <= '0;
                pcnt     <= '0;
                irled_en <= 1'b1;
                ir_pu    <= cfg_boost;
                busy     <= 1'b1;
                state    <= (cfg_settle != '0) ? SETTLE : BURST;
                ir_pwm   <= (cfg_settle == '0) && (cfg_duty != '0);
            end else if (state != IDLE && !cfg_enable) begin
                state    <= IDLE;
                set_cnt  <= '0;
                phase    <= '0;
                pcnt     <= '0;
                irled_en <= 1'b0;
                ir_pwm   <= 1'b0;
                ir_pu    <= 1'b0;
                busy     <= 1'b0;
            end else if (state == SETTLE) begin
                if (set_cnt == settle_q - ONE) begin
                    state  <= BURST;
                    ir_pwm <= duty_q != '0;
                end else begin
                    set_cnt <= set_cnt + ONE;
                end
            end else if (state == BURST) begin
                if (phase == per_q - ONE) begin
                    phase <= '0;
                    if (pcnt == pulses_q - ONE) begin
                        state    <= IDLE;
                        pcnt     <= '0;
                        irled_en <= 1'b0;
                        ir_pwm   <= 1'b0;
                        ir_pu    <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        pcnt   <= pcnt + ONE;
                        ir_pwm <= duty_q != '0;
                    end
                end else begin
                    phase  <= phase + ONE;
                    ir_pwm <= (phase + ONE) < duty_q;
                end
            end
        end
    end
endmodule

// File: doc/ir_strobe_ctrl.md
Name: ir_strobe_ctrl

Overview:
- Sequencer directly upstream of the IR LED driver primitive; drives its enable, PWM and current-boost inputs.
- On a trigger, typically camera frame-start, it powers up the IR LED driver and waits a programmable settle time.
- It then emits a fixed-length burst of carrier PWM and returns the driver to off.
- Configuration is latched at trigger so firmware may rewrite registers mid-burst.

Parameters:
- CNT_W, 16, width of period/duty/settle/count config fields and internal counters.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- cfg_enable  input  1  block enable; low forces abort/idle
- cfg_period  input  CNT_W  carrier period in clk cycles (0 treated as 1)
- cfg_duty  input  CNT_W  carrier high time in clk cycles
- cfg_settle  input  CNT_W  clocks between irled_en rise and first carrier cycle
- cfg_pulses  input  CNT_W  number of carrier periods per burst
- cfg_boost  input  1  request high-current mode (drives ir_pu during strobe)
- trigger  input  1  single-cycle strobe request
- ovr_clr  input  1  clears overrun flag
- irled_en  output  1  to driver IRLED_EN
- ir_pwm  output  1  to driver IR_PWM
- ir_pu  output  1  to driver IR_PU
- busy  output  1  high in SETTLE or BURST
- done  output  1  one-cycle pulse at burst completion
- overrun  output  1  sticky: trigger arrived while busy

Behaviour:
- All outputs are registered. Reset is asynchronous: every output is 0, state is IDLE, and all counters are 0.
- States are IDLE, SETTLE and BURST.
- IDLE:
  - The block accepts a trigger only when trigger=1, cfg_enable=1 and cfg_pulses!=0.
  - On accept it latches period (max(cfg_period,1)), duty, settle, pulses and boost.
  - If settle>0: at the same edge irled_en=1, ir_pu=boost_latched, busy=1, state goes to SETTLE with settle counter=0.
  - If settle=0: the block goes straight to BURST at that edge (see BURST).
  - A trigger with cfg_pulses=0 or cfg_enable=0 is ignored. It does not set overrun.
- SETTLE:
  - ir_pwm=0 and the settle counter increments each clk.
  - When the counter reaches settle-1, the next edge enters BURST.
  - Result: irled_en is high exactly settle cycles before the first ir_pwm cycle.
- BURST:
  - Phase counter runs 0..period-1 and wraps. The pulse counter increments on each wrap.
  - Each cycle, ir_pwm is registered as (phase < duty).
  - duty=0 gives a constant low. duty>=period gives a constant high for the whole burst.
  - The burst occupies exactly pulses*period clocks.
  - At the edge after phase=period-1 of the final pulse: state=IDLE, irled_en=0, ir_pu=0, ir_pwm=0, busy=0, done=1 for one cycle.
- Latency: trigger high at edge k means irled_en is high from edge k. The first ir_pwm high is at edge k+settle (when duty>0).
- Overrun:
  - A trigger while busy=1 is ignored and sets overrun=1.
  - overrun holds until ovr_clr=1, which clears it at the next edge.
  - If the set and clear conditions occur in the same cycle, set wins.
- A trigger on the same cycle as done is still a busy-cycle trigger: it is ignored and sets overrun. No back-to-back strobes; at least one IDLE cycle is needed.
- Abort: cfg_enable=0 in SETTLE or BURST returns the block to IDLE at the next edge with irled_en, ir_pwm, ir_pu and busy=0. done is not pulsed.
- Config writes while busy have no effect until the next accepted trigger.
- Counters are CNT_W wide with no overflow. The maximum burst is (2^CNT_W-1)^2 clocks.
- ir_pwm=1 only when irled_en=1. ir_pu=1 only when irled_en=1.

Test Plan:
- Basic strobe: period=4, duty=1, settle=3, pulses=2, boost=1; trigger at cycle 10.
  - irled_en and ir_pu are high on cycles 10–20.
  - ir_pwm is high on cycles 13 and 17.
  - done pulses on cycle 21 and busy falls on cycle 21.
- Duty extremes: period=5, pulses=3, settle=0.
  - duty=0: ir_pwm stays 0 for the 15-cycle burst.
  - duty=7: ir_pwm is high for exactly 15 cycles, starting at the trigger edge.
- Overrun: trigger again 5 cycles into a busy burst.
  - The burst length is unchanged and overrun=1.
  - ovr_clr pulse gives overrun=0 next cycle. Simultaneous trigger-while-busy plus ovr_clr leaves overrun=1.
- Abort: drop cfg_enable mid-BURST.
  - Next cycle: irled_en=ir_pwm=ir_pu=busy=0, no done pulse.
  - A subsequent trigger with enable=1 starts a fresh full burst.
- Config isolation and ignored triggers:
  - Change cfg_period 4→9 mid-burst: the current burst keeps period 4 and the next burst uses period 9.
  - A trigger with pulses=0 produces no output activity and overrun stays 0.
- Async reset: assert rst mid-SETTLE between clock edges.
  - All outputs drop immediately.
  - After release, outputs stay idle until the next trigger.
